fanout_fork_buffered: RTL and testbench

//  Registered, parametrised successor to the hashed fanout ready-join. Accepts one token per

---
 rtl/fanout_fork_buffered_pkg.sv | 13 +
 rtl/fanout_fork_buffered_if.sv | 24 ++
 rtl/fanout_fork_buffered_ready_join.sv | 31 +++
 rtl/fanout_fork_buffered.sv | 83 ++++++++
 tb/tb_fanout_fork_buffered.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fanout_fork_buffered_pkg.sv
// Shared types for the buffered fan-out fork: delivery modes and destination masks.
package fanout_pkg;

  localparam int NUM_OUT_MAX = 32;

  typedef logic [NUM_OUT_MAX-1:0] dest_mask_t;

  typedef enum logic {
    FORK_LOCKSTEP = 1'b0,
    FORK_EAGER    = 1'b1
  } fork_mode_e;

endpackage

// File: rtl/fanout_fork_buffered_if.sv
// Token handshake bundle: one upstream valid/ready port and a shared-data broadcast port.
interface fanout_fork_buffered_if #(
  parameter int NUM_OUT = 7,
  parameter int DATA_W  = 17
);

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/fanout_fork_buffered_ready_join.sv
// Combinational per-channel valid generation and completion reduction for the held token.
import fanout_pkg::*;

module fanout_ready_join #(
  parameter int NUM_OUT = 7
) (
  input  logic [NUM_OUT-1:0] dest,
  input  logic [NUM_OUT-1:0] sent,
  input  logic [NUM_OUT-1:0] ready,
  input  logic               full,
  input  fork_mode_e         mode,
  output logic [NUM_OUT-1:0] valid,
  output logic               complete
);

  logic all_rdy;

  // Unselected channels behave as permanently ready so they never block the join.
  assign all_rdy = &(~dest | ready);

  always_comb begin
    valid = '0;
    if (full) begin
      if (mode == FORK_EAGER) valid = dest & ~sent;
      else                    valid = dest & {NUM_OUT{all_rdy}};
    end
  end

  assign complete = full & (&(~dest | sent | (valid & ready)));

endmodule

// File: rtl/fanout_fork_buffered.sv
// One-deep token buffer broadcasting to a masked set of consumers, eager or lockstep.
// Tokens retire once every selected channel has taken them; stall_cnt counts held-token wait cycles.
import fanout_pkg::*;

module fanout_fork_buffered #(
  parameter int NUM_OUT = 7,
  parameter int DATA_W  = 17,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NUM_OUT-1:0]     cfg_en,
  input  logic [NUM_OUT-1:0]     cfg_sel,
  input  logic                   cfg_eager,
  fanout_fork_buffered_if.slave  bus,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic               full;
  logic [DATA_W-1:0]  data_q;
  logic [NUM_OUT-1:0] dest_q;
  logic [NUM_OUT-1:0] sent_q;
  fork_mode_e         mode_q;
  logic [CNT_W-1:0]   stall_q;

  logic [NUM_OUT-1:0] join_valid;
  logic               complete;
  logic               live;
  logic               accept;
  logic [NUM_OUT-1:0] fire;

  fanout_ready_join #(.NUM_OUT(NUM_OUT)) u_join (
    .dest     (dest_q),
    .sent     (sent_q),
    .ready    (bus.out_ready),
    .full     (full),
    .mode     (mode_q),
    .valid    (join_valid),
    .complete (complete)
  );

  // Reset and flush both silence the handshake for the cycle they are asserted.
  assign live          = rst_n & ~flush;
  assign bus.in_ready  = live & (~full | complete);
  assign bus.out_valid = live ? join_valid : '0;
  assign bus.out_data  = data_q;
  assign stall_cnt     = stall_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign fire   = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full    <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      sent_q  <= '0;
      mode_q  <= FORK_LOCKSTEP;
      stall_q <= '0;
    end else if (flush) begin
      full   <= 1'b0;
      sent_q <= '0;
    end else begin
      if (accept) begin
        full   <= 1'b1;
        data_q <= bus.in_data;
        dest_q <= cfg_en & cfg_sel;
        mode_q <= fork_mode_e'(cfg_eager);
        sent_q <= '0;
      end else if (complete) begin
        full   <= 1'b0;
        sent_q <= '0;
      end else begin
        sent_q <= sent_q | fire;
      end

      if (full && !complete && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanout_fork_buffered.sv
// Directed self-checking bench for fanout_fork_buffered with NUM_OUT=7, DATA_W=17.
module tb_fanout_fork_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [6:0]  cfg_en;
  logic [6:0]  cfg_sel;
  logic        cfg_eager;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  fanout_fork_buffered_if #(.NUM_OUT(7), .DATA_W(17)) bus ();

  fanout_fork_buffered #(.NUM_OUT(7), .DATA_W(17), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cfg_en    (cfg_en),
    .cfg_sel   (cfg_sel),
    .cfg_eager (cfg_eager),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    cfg_en = '0; cfg_sel = '0; cfg_eager = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = '0;

    // Reset
    tick(); tick();
    settle();
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_stall",     32'(stall_cnt),     32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    rst_n = 1'b1;
    settle();
    chk("idle_in_ready", 32'(bus.in_ready),  32'h1);

    // 1. Eager partial delivery
    cfg_en = 7'h7F; cfg_sel = 7'h05; cfg_eager = 1'b1;
    bus.in_data = 17'h00AB; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("t1_out_valid", 32'(bus.out_valid), 32'h05);
    chk("t1_in_ready",  32'(bus.in_ready),  32'h0);
    chk("t1_out_data",  32'(bus.out_data),  32'h00AB);
    bus.out_ready = 7'h01;
    tick();
    settle();
    chk("t1_after_ch0", 32'(bus.out_valid), 32'h04);
    chk("t1_in_rdy_b",  32'(bus.in_ready),  32'h0);
    chk("t1_stall",     32'(stall_cnt),     32'h1);
    bus.out_ready = 7'h05;
    settle();
    chk("t1_complete",  32'(bus.in_ready),  32'h1);
    tick();
    settle();
    chk("t1_retired",   32'(bus.out_valid), 32'h0);
    chk("t1_stall_hold",32'(stall_cnt),     32'h1);

    rst_n = 1'b0; bus.out_ready = '0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("t2_rst_stall", 32'(stall_cnt), 32'h0);

    // 2. Lockstep waits for all selected consumers
    cfg_eager = 1'b0; cfg_sel = 7'h03;
    bus.in_data = 17'h1234; bus.in_valid = 1'b1; bus.out_ready = 7'h01;
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("t2_no_valid",  32'(bus.out_valid), 32'h0);
    tick(); tick(); tick();
    settle();
    chk("t2_stall3",    32'(stall_cnt),     32'h3);
    chk("t2_still_no",  32'(bus.out_valid), 32'h0);
    bus.out_ready = 7'h03;
    settle();
    chk("t2_fire",      32'(bus.out_valid), 32'h03);
    chk("t2_in_ready",  32'(bus.in_ready),  32'h1);
    tick();
    settle();
    chk("t2_retired",   32'(bus.out_valid), 32'h0);
    chk("t2_stall_hold",32'(stall_cnt),     32'h3);

    // 3. Back-to-back eager broadcast, 8 tokens in 9 cycles
    cfg_eager = 1'b1; cfg_sel = 7'h7F; bus.out_ready = 7'h7F;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 17'(32'h100 + i); bus.in_valid = 1'b1;
      settle();
      chk("t3_in_ready", 32'(bus.in_ready), 32'h1);
      if (i > 0) begin
        chk("t3_data",  32'(bus.out_data),  32'h100 + 32'(i - 1));
        chk("t3_valid", 32'(bus.out_valid), 32'h7F);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    settle();
    chk("t3_last_data", 32'(bus.out_data),  32'h107);
    chk("t3_last_vld",  32'(bus.out_valid), 32'h7F);
    tick();
    settle();
    chk("t3_drained",   32'(bus.out_valid), 32'h0);
    chk("t3_stall",     32'(stall_cnt),     32'h3);

    // 4. No destinations: token is dropped one cycle after accept
    cfg_en = 7'h00; bus.out_ready = '0;
    bus.in_data = 17'h0055; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("t4_no_valid",  32'(bus.out_valid), 32'h0);
    chk("t4_in_ready",  32'(bus.in_ready),  32'h1);
    tick();
    settle();
    chk("t4_stall",     32'(stall_cnt),     32'h3);

    // 5. Config snapshot per token
    cfg_en = 7'h7F; cfg_sel = 7'h01; cfg_eager = 1'b1;
    bus.in_data = 17'h00A1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; cfg_sel = 7'h02;
    settle();
    chk("t5_held_ch0",  32'(bus.out_valid), 32'h01);
    tick();
    settle();
    chk("t5_held_ch0b", 32'(bus.out_valid), 32'h01);
    chk("t5_stall",     32'(stall_cnt),     32'h4);
    bus.out_ready = 7'h01;
    bus.in_data = 17'h00A2; bus.in_valid = 1'b1;
    settle();
    chk("t5_b2b_rdy",   32'(bus.in_ready),  32'h1);
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 7'h02;
    settle();
    chk("t5_next_ch1",  32'(bus.out_valid), 32'h02);
    chk("t5_next_data", 32'(bus.out_data),  32'h00A2);
    tick();
    settle();
    chk("t5_retired",   32'(bus.out_valid), 32'h0);
    chk("t5_stall_b",   32'(stall_cnt),     32'h4);

    // 6. Flush mid-delivery, then reset mid-token
    cfg_sel = 7'h03; bus.out_ready = '0;
    bus.in_data = 17'h00B0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 7'h01;
    tick();
    bus.out_ready = '0;
    settle();
    chk("t6_partial",   32'(bus.out_valid), 32'h02);
    chk("t6_stall",     32'(stall_cnt),     32'h5);
    flush = 1'b1;
    settle();
    chk("t6_fl_rdy",    32'(bus.in_ready),  32'h0);
    chk("t6_fl_vld",    32'(bus.out_valid), 32'h0);
    tick();
    flush = 1'b0;
    settle();
    chk("t6_empty_vld", 32'(bus.out_valid), 32'h0);
    chk("t6_empty_rdy", 32'(bus.in_ready),  32'h1);
    chk("t6_stall_hld", 32'(stall_cnt),     32'h5);

    bus.in_data = 17'h00C0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    settle();
    chk("t6_stall_b",   32'(stall_cnt),     32'h6);
    rst_n = 1'b0;
    settle();
    chk("t6_rst_rdy",   32'(bus.in_ready),  32'h0);
    chk("t6_rst_vld",   32'(bus.out_valid), 32'h0);
    tick();
    settle();
    chk("t6_rst_stall", 32'(stall_cnt),     32'h0);
    chk("t6_rst_data",  32'(bus.out_data),  32'h0);
    rst_n = 1'b1;
    settle();
    chk("t6_post_vld",  32'(bus.out_valid), 32'h0);
    chk("t6_post_rdy",  32'(bus.in_ready),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
